// File: rtl/numlock_pkg.sv
// Shared definitions for the number-lock button path: one-hot debounce states and default timing.
package numlock_pkg;

  localparam int DEBOUNCE_CNT_DEF = 2**20;
  localparam int REPEAT_CNT_DEF   = 2**24;
  localparam int CNT_W_DEF        = 25;

  // Bit positions inside the 6-bit debug state vector, MSB first
  localparam int INI_B  = 5;
  localparam int WQ_B   = 4;
  localparam int SCEN_B = 3;
  localparam int WS_B   = 2;
  localparam int MCEN_B = 1;
  localparam int WFCR_B = 0;

  typedef enum logic [5:0] {
    INI     = 6'b100000,
    WQ      = 6'b010000,
    SCEN_ST = 6'b001000,
    WS      = 6'b000100,
    MCEN_ST = 6'b000010,
    WFCR    = 6'b000001
  } db_state_t;

endpackage

// File: rtl/numlock_sync2.sv
// Two-flop synchroniser for an asynchronous level input; clears to 0 on reset.
module numlock_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/numlock_btn_debounce.sv
// Push-button conditioner: synchronise, debounce, and derive single/repeat/continuous enables.
module numlock_btn_debounce
  import numlock_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int REPEAT_CNT   = REPEAT_CNT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PB,
  output logic       DPB,
  output logic       SCEN,
  output logic       MCEN,
  output logic       CCEN,
  output logic [5:0] state
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CNT - 1);

  logic             pbs;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  numlock_sync2 u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (PB),
    .q    (pbs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Input level is always tested before the count terminal
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INI: begin
        if (pbs) begin
          state_d = WQ;
          cnt_d   = '0;
        end
      end
      WQ: begin
        if (!pbs)                 state_d = INI;
        else if (cnt_q == DB_LAST) begin
          state_d = SCEN_ST;
          cnt_d   = '0;
        end else                  cnt_d = cnt_q + CNT_W'(1);
      end
      SCEN_ST: begin
        state_d = WS;
        cnt_d   = '0;
      end
      WS: begin
        if (!pbs) begin
          state_d = WFCR;
          cnt_d   = '0;
        end else if (cnt_q == RP_LAST) state_d = MCEN_ST;
        else                           cnt_d = cnt_q + CNT_W'(1);
      end
      MCEN_ST: begin
        state_d = WS;
        cnt_d   = '0;
      end
      WFCR: begin
        // A bounce back high restarts the quiet window without a new press
        if (pbs)                   cnt_d = '0;
        else if (cnt_q == DB_LAST) state_d = INI;
        else                       cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = INI;
        cnt_d   = '0;
      end
    endcase
  end

  assign SCEN  = (state_q == SCEN_ST);
  assign MCEN  = (state_q == SCEN_ST) || (state_q == MCEN_ST);
  assign CCEN  = (state_q == SCEN_ST) || (state_q == WS) || (state_q == MCEN_ST);
  assign DPB   = CCEN || (state_q == WFCR);
  assign state = state_q;

endmodule

// File: tb/tb_numlock_btn_debounce.sv
// Directed bench for the button debouncer at DEBOUNCE_CNT=4, REPEAT_CNT=8.
module tb_numlock_btn_debounce;

  localparam logic [5:0] S_INI  = 6'b100000;
  localparam logic [5:0] S_WQ   = 6'b010000;
  localparam logic [5:0] S_SCEN = 6'b001000;
  localparam logic [5:0] S_WS   = 6'b000100;
  localparam logic [5:0] S_MCEN = 6'b000010;
  localparam logic [5:0] S_WFCR = 6'b000001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       PB = 1'b0;
  logic       DPB, SCEN, MCEN, CCEN;
  logic [5:0] state;

  int n_chk = 0;
  int n_err = 0;

  numlock_btn_debounce #(
    .DEBOUNCE_CNT(4),
    .REPEAT_CNT  (8),
    .CNT_W       (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .PB   (PB),
    .DPB  (DPB),
    .SCEN (SCEN),
    .MCEN (MCEN),
    .CCEN (CCEN),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press from an idle INI state; PB is first sampled at edge 1
  task automatic press(output int first_scen, output int n_scen, output int first_mcen);
    first_scen = 0;
    n_scen     = 0;
    first_mcen = 0;
    PB = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (SCEN) begin
        n_scen++;
        if (first_scen == 0) first_scen = e;
      end
      if (MCEN && first_mcen == 0) first_mcen = e;
    end
  endtask

  int fs, ns, fm, nm, ccen_low, dpb_fall, seen_scen, seen_dpb;
  int mcen_e [3];

  initial begin
    // 1: reset held for 3 cycles
    for (int i = 0; i < 3; i++) step();
    chk("rst_state", 32'(state), 32'(S_INI));
    chk("rst_dpb",   32'(DPB),  0);
    chk("rst_scen",  32'(SCEN), 0);
    chk("rst_mcen",  32'(MCEN), 0);
    chk("rst_ccen",  32'(CCEN), 0);
    reset = 1'b0;
    step();
    chk("idle_state", 32'(state), 32'(S_INI));

    // 2: short 3-cycle press is rejected in WQ
    seen_scen = 0;
    seen_dpb  = 0;
    PB = 1'b1;
    for (int e = 1; e <= 3; e++) step();
    chk("glitch_wq", 32'(state), 32'(S_WQ));
    PB = 1'b0;
    for (int e = 4; e <= 8; e++) begin
      step();
      if (SCEN) seen_scen++;
      if (DPB)  seen_dpb++;
    end
    chk("glitch_ini",  32'(state), 32'(S_INI));
    chk("glitch_scen", 32'(seen_scen), 0);
    chk("glitch_dpb",  32'(seen_dpb), 0);

    // 3: held press, SCEN/MCEN at edge 7
    press(fs, ns, fm);
    chk("press_scen_edge", 32'(fs), 7);
    chk("press_scen_cnt",  32'(ns), 1);
    chk("press_mcen_edge", 32'(fm), 7);
    chk("press_state",     32'(state), 32'(S_SCEN));
    step();
    chk("hold_scen_lo", 32'(SCEN), 0);
    chk("hold_mcen_lo", 32'(MCEN), 0);
    chk("hold_dpb",     32'(DPB), 1);
    chk("hold_ccen",    32'(CCEN), 1);
    chk("hold_state",   32'(state), 32'(S_WS));

    // 4: repeats every 9 cycles, edges 16, 25, 34
    nm = 0;
    ns = 0;
    ccen_low = 0;
    for (int e = 9; e <= 34; e++) begin
      step();
      if (MCEN && nm < 3) begin
        mcen_e[nm] = e;
        nm++;
      end
      if (SCEN) ns++;
      if (!CCEN || !DPB) ccen_low++;
    end
    chk("rep_count", 32'(nm), 3);
    chk("rep_mcen0", 32'(mcen_e[0]), 16);
    chk("rep_mcen1", 32'(mcen_e[1]), 25);
    chk("rep_mcen2", 32'(mcen_e[2]), 34);
    chk("rep_scen",  32'(ns), 0);
    chk("rep_ccen",  32'(ccen_low), 0);

    // 5: release at edge 35, bounce high sampled at edges 38-39
    dpb_fall = 0;
    ns = 0;
    for (int e = 35; e <= 46; e++) begin
      PB = (e == 38 || e == 39);
      step();
      if (e == 37) chk("rel_wfcr", 32'(state), 32'(S_WFCR));
      if (!DPB && dpb_fall == 0) dpb_fall = e;
      if (SCEN) ns++;
    end
    chk("rel_dpb_fall", 32'(dpb_fall), 45);
    chk("rel_scen",     32'(ns), 0);
    chk("rel_state",    32'(state), 32'(S_INI));

    // 6: reset while in WS, then a fresh press
    press(fs, ns, fm);
    for (int e = 8; e <= 10; e++) step();
    chk("ws_before_rst", 32'(state), 32'(S_WS));
    reset = 1'b1;
    step();
    chk("mid_rst_state", 32'(state), 32'(S_INI));
    chk("mid_rst_outs",  32'({DPB, SCEN, MCEN, CCEN}), 0);
    PB = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_state", 32'(state), 32'(S_INI));
    press(fs, ns, fm);
    chk("repress_scen_edge", 32'(fs), 7);
    chk("repress_scen_cnt",  32'(ns), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
